// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch stage: owns the fetch PC, issues word requests to the
// instruction memory, and fills the IF/ID pipeline register. It supports
// decode back-pressure (stall), pipeline redirects (flush), and memory
// responses of arbitrary latency.
//
// States:
//   IDLE  - one cycle after reset. No request is made, and any ack is ignored.
//   FETCH - a request at pc is outstanding until imem_ack.
//   HOLD  - a response arrived while decode was stalled. It is parked in the
//           skid register until decode accepts it.
//   DRAIN - a redirect came while a request was still unacked. The old request
//           is kept on the bus until its ack arrives, and that data is dropped.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   next_pc     next PC from the upstream next-PC mux (pc_plus4 or a target)
//   stall       decode cannot accept; hold the IF/ID outputs
//   flush       redirect; squash the fetched and in-flight instruction
//   imem_req    instruction-memory request
//   imem_addr   instruction-memory word address
//   imem_ack    memory response valid, one pulse per request
//   imem_rdata  instruction word, valid with imem_ack
//   pc          current fetch PC
//   pc_plus4    pc + 4 modulo 2^32
//   if_valid    IF/ID register holds a valid instruction
//   if_pc       PC of if_instr
//   if_instr    fetched instruction
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] skid_pc, skid_instr;
    logic [31:0] drain_addr;

    logic pc_load;       // pc <= word-aligned next_pc
    logic if_load_mem;   // IF/ID <= memory response
    logic if_load_skid;  // IF/ID <= skid register
    logic if_bubble;     // if_valid <= 0
    logic skid_load;     // park the response in the skid register
    logic drain_load;    // remember the abandoned request address

    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        pc_load      = 1'b0;
        if_load_mem  = 1'b0;
        if_load_skid = 1'b0;
        if_bubble    = 1'b0;
        skid_load    = 1'b0;
        drain_load   = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                pc_load   = flush;
                if_bubble = flush;
            end
            FETCH: begin
                if (flush) begin
                    // A redirect takes priority over stall and ack.
                    if_bubble = 1'b1;
                    pc_load   = 1'b1;
                    if (!imem_ack) begin
                        state_nxt  = DRAIN;
                        drain_load = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (!stall) begin
                        if_load_mem = 1'b1;
                        pc_load     = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_nxt = HOLD;
                    end
                end else if (!stall) begin
                    if_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    // The parked response is abandoned and never read again.
                    if_bubble = 1'b1;
                    pc_load   = 1'b1;
                    state_nxt = FETCH;
                end else if (!stall) begin
                    if_load_skid = 1'b1;
                    pc_load      = 1'b1;
                    state_nxt    = FETCH;
                end
            end
            DRAIN: begin
                // The redirect has already been taken. A further flush only
                // retargets pc, and the late response is discarded.
                pc_load = flush;
                if (imem_ack) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever the statement order.
    // NOTE: every register, including skid and drain, has a defined reset
    // value. This lets the outputs and internal state come up deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            if_valid   <= 1'b0;
            if_pc      <= 32'd0;
            if_instr   <= 32'd0;
            skid_pc    <= 32'd0;
            skid_instr <= 32'd0;
            drain_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (pc_load) pc <= {next_pc[31:2], 2'b00};
            if (drain_load) drain_addr <= pc;
            if (skid_load) begin
                skid_pc    <= pc;
                skid_instr <= imem_rdata;
            end
            if (if_load_mem) begin
                if_pc    <= pc;
                if_instr <= imem_rdata;
                if_valid <= 1'b1;
            end else if (if_load_skid) begin
                if_pc    <= skid_pc;
                if_instr <= skid_instr;
                if_valid <= 1'b1;
            end else if (if_bubble) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule
